// File: rtl/jtpopeye_dwnld.sv
// Routes ioctl download bytes to the SDRAM programming port (with a one-entry skid buffer)
// or to the colour/timing PROM write strobes, and flags end of download and overflow.
module jtpopeye_dwnld #(
    parameter logic [21:0] PROM_START = 22'hE000,
    parameter logic [21:0] FILE_END   = 22'hE240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    input  logic        prog_rdy,
    output logic [3:0]  prom_we,
    output logic [7:0]  prom_addr,
    output logic [7:0]  prom_data,
    output logic        dwnld_done,
    output logic        dwnld_err
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q, state_d;
    logic [21:0] out_addr_q, out_addr_d;
    logic [7:0]  out_data_q, out_data_d;
    logic [1:0]  out_mask_q, out_mask_d;
    logic        skid_valid_q, skid_valid_d;
    logic [21:0] skid_addr_q, skid_addr_d;
    logic [7:0]  skid_data_q, skid_data_d;
    logic [1:0]  skid_mask_q, skid_mask_d;
    logic [3:0]  prom_we_q, prom_we_d;
    logic [7:0]  prom_addr_q, prom_addr_d;
    logic [7:0]  prom_data_q, prom_data_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        dl_q;
    logic        fall_seen_q, fall_seen_d;

    logic        wr_en, is_sdram, is_prom, sdram_wr, prom_wr;
    logic [21:0] prom_off;
    logic [21:0] new_addr;
    logic [1:0]  new_mask;
    logic [3:0]  prom_sel;
    logic [7:0]  prom_idx;
    logic        overflow;
    logic        fall_pending;

    assign wr_en    = ioctl_wr & downloading;
    assign is_sdram = ioctl_addr < PROM_START;
    assign is_prom  = !is_sdram && (ioctl_addr < FILE_END);
    assign sdram_wr = wr_en & is_sdram;
    assign prom_wr  = wr_en & is_prom;
    assign prom_off = ioctl_addr - PROM_START;
    assign new_addr = {1'b0, ioctl_addr[21:1]};
    assign new_mask = ioctl_addr[0] ? 2'b01 : 2'b10;

    // Only the low byte of the offset survives into the PROM address, so the
    // per-PROM base can be removed with 8-bit arithmetic.
    always_comb begin
        prom_sel = 4'b0000;
        prom_idx = 8'h00;
        if (prom_off < 22'h020) begin
            prom_sel = 4'b0001;
            prom_idx = prom_off[7:0];
        end else if (prom_off < 22'h040) begin
            prom_sel = 4'b0010;
            prom_idx = prom_off[7:0] - 8'h20;
        end else if (prom_off < 22'h140) begin
            prom_sel = 4'b0100;
            prom_idx = prom_off[7:0] - 8'h40;
        end else begin
            prom_sel = 4'b1000;
            prom_idx = prom_off[7:0] - 8'h40;
        end
    end

    always_comb begin
        prom_we_d   = 4'b0000;
        prom_addr_d = prom_addr_q;
        prom_data_d = prom_data_q;
        if (prom_wr) begin
            prom_we_d   = prom_sel;
            prom_addr_d = prom_idx;
            prom_data_d = ioctl_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        out_mask_d   = out_mask_q;
        skid_valid_d = skid_valid_q;
        skid_addr_d  = skid_addr_q;
        skid_data_d  = skid_data_q;
        skid_mask_d  = skid_mask_q;
        overflow     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sdram_wr) begin
                    out_addr_d = new_addr;
                    out_data_d = ioctl_data;
                    out_mask_d = new_mask;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                if (prog_rdy) begin
                    if (skid_valid_q) begin
                        out_addr_d   = skid_addr_q;
                        out_data_d   = skid_data_q;
                        out_mask_d   = skid_mask_q;
                        skid_valid_d = 1'b0;
                        if (sdram_wr) begin
                            skid_addr_d  = new_addr;
                            skid_data_d  = ioctl_data;
                            skid_mask_d  = new_mask;
                            skid_valid_d = 1'b1;
                        end
                    end else if (sdram_wr) begin
                        out_addr_d = new_addr;
                        out_data_d = ioctl_data;
                        out_mask_d = new_mask;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (sdram_wr) begin
                    if (skid_valid_q) begin
                        overflow = 1'b1;
                    end else begin
                        skid_addr_d  = new_addr;
                        skid_data_d  = ioctl_data;
                        skid_mask_d  = new_mask;
                        skid_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Done is judged on the next-cycle pipeline state so it pulses in the cycle
    // right after the final prog_rdy.
    always_comb begin
        err_d = err_q;
        if (overflow) begin
            err_d = 1'b1;
        end else if (downloading && !dl_q) begin
            err_d = 1'b0;
        end
        fall_pending = fall_seen_q | (dl_q & ~downloading);
        done_d       = ~downloading & fall_pending & (state_d == StIdle) & ~skid_valid_d;
        fall_seen_d  = fall_pending & ~done_d & ~downloading;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            out_mask_q   <= 2'b11;
            skid_valid_q <= 1'b0;
            skid_addr_q  <= '0;
            skid_data_q  <= '0;
            skid_mask_q  <= 2'b11;
            prom_we_q    <= '0;
            prom_addr_q  <= '0;
            prom_data_q  <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            dl_q         <= 1'b0;
            fall_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            out_mask_q   <= out_mask_d;
            skid_valid_q <= skid_valid_d;
            skid_addr_q  <= skid_addr_d;
            skid_data_q  <= skid_data_d;
            skid_mask_q  <= skid_mask_d;
            prom_we_q    <= prom_we_d;
            prom_addr_q  <= prom_addr_d;
            prom_data_q  <= prom_data_d;
            err_q        <= err_d;
            done_q       <= done_d;
            dl_q         <= downloading;
            fall_seen_q  <= fall_seen_d;
        end
    end

    assign prog_addr  = out_addr_q;
    assign prog_data  = out_data_q;
    assign prog_mask  = out_mask_q;
    assign prog_we    = (state_q == StBusy);
    assign prom_we    = prom_we_q;
    assign prom_addr  = prom_addr_q;
    assign prom_data  = prom_data_q;
    assign dwnld_done = done_q;
    assign dwnld_err  = err_q;

endmodule

// File: doc/jtpopeye_dwnld.md
# jtpopeye_dwnld

ROM download router between the frame's ioctl download port and both the SDRAM programming port and the on-chip colour/timing PROMs. It decodes each downloaded byte by file offset and turns it into either a held SDRAM byte write with a `prog_rdy` handshake or a single-cycle PROM write strobe. A one-entry skid buffer absorbs a download byte that arrives while an SDRAM write is still outstanding. It also reports the end of the download and any overflow.

## Interface
Parameters:
- `PROM_START`, 22'hE000, file offset of the first PROM byte; lower offsets go to SDRAM.
- `FILE_END`, 22'hE240, first offset past the valid file; bytes at or above it are dropped.

Ports:
- `clk` in 1: system clock, 40 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `downloading` in 1: download in progress.
- `ioctl_addr` in 22: byte offset in the file.
- `ioctl_data` in 8: byte value.
- `ioctl_wr` in 1: one-cycle byte strobe.
- `prog_addr` out 22: SDRAM word address.
- `prog_data` out 8: byte to write.
- `prog_mask` out 2: byte-lane mask, active low.
- `prog_we` out 1: SDRAM write request.
- `prog_rdy` in 1: SDRAM write accepted.
- `prom_we` out 4: one-hot PROM write strobe.
- `prom_addr` out 8: PROM address.
- `prom_data` out 8: PROM data.
- `dwnld_done` out 1: one-cycle pulse at the end of the download.
- `dwnld_err` out 1: sticky overflow flag.

## Operation
- Reset value of all outputs is 0, except `prog_mask`, which resets to 2'b11.
- Address decode is applied to `ioctl_addr` on each `ioctl_wr`.
- **SDRAM range, `a < PROM_START`:**
  - `prog_addr = {1'b0, a[21:1]}`.
  - `prog_mask = a[0] ? 2'b01 : 2'b10`.
- **PROM range, `PROM_START <= a < FILE_END`**, with `o = a - PROM_START`:
  - o 0x000–0x01F: `prom_we[0]` (background palette).
  - o 0x020–0x03F: `prom_we[1]` (character palette).
  - o 0x040–0x13F: `prom_we[2]` (sprite palette).
  - o 0x140–0x23F: `prom_we[3]` (timing).
  - `prom_addr` is the offset within the selected PROM, zero-extended to 8 bits.
- **At or above `FILE_END`:** the byte is dropped and no strobe is issued.
- **SDRAM path FSM**, states IDLE and BUSY:
  - IDLE + SDRAM byte → load the output registers, assert `prog_we`, go to BUSY.
  - BUSY + `prog_rdy` → if the skid buffer is full, load it into the outputs and stay in BUSY (`prog_we` remains 1); otherwise drop `prog_we` and go to IDLE.
  - BUSY + new SDRAM byte → store it in the skid buffer.
  - BUSY + new SDRAM byte while the skid buffer is full and `prog_rdy` is 0 → drop the byte and set `dwnld_err`.
  - `prog_rdy` in the same cycle as a new byte, with the skid buffer empty → the new byte goes directly to the outputs; no skid is used.
- **PROM path:** it is independent of the FSM and never stalls. PROM bytes are never buffered.
- **`dwnld_err`:** cleared on the rising edge of `downloading`.
- **`dwnld_done`:** pulses once when `downloading` is 0, a fall of `downloading` has been seen, the FSM is in IDLE, and the skid buffer is empty.
- **`ioctl_wr` while `downloading` = 0:** ignored.
- **Reset mid-operation:** aborts any pending write and empties the skid buffer.

## Timing
- `ioctl_wr` at cycle N (SDRAM byte, FSM in IDLE) → `prog_we`, `prog_addr`, `prog_data` and `prog_mask` are valid from N+1.
- `prog_we` and the SDRAM outputs are held stable until `prog_rdy` is sampled high.
- If `prog_rdy` is sampled at M with nothing queued, `prog_we` = 0 at M+1.
- If `prog_rdy` is sampled at M with the skid buffer full, the buffered byte is on the outputs at M+1.
- PROM byte: `ioctl_wr` at N → `prom_we` is high for exactly cycle N+1, with address and data valid in that cycle.
- `downloading` falls at F with the pipeline empty → `dwnld_done` is high at F+1 only.
- `downloading` falls at F with a write pending → `dwnld_done` is high one cycle after the FSM returns to IDLE with the skid buffer empty.

## Test plan
- **Even SDRAM byte:** write 0x5A at offset 0x0124, hold `prog_rdy` low for 3 cycles.
  - `prog_addr` = 0x000092, `prog_mask` = 2'b10, `prog_data` = 0x5A.
  - `prog_we` stays high until one cycle after `prog_rdy`.
- **Back-to-back odd/even bytes:** write offset 0x0125 then 0x0126 one cycle apart, with `prog_rdy` delayed.
  - The second byte is served from the skid buffer.
  - `prog_we` never drops between the two writes.
  - `dwnld_err` = 0.
- **Overflow:** send three SDRAM bytes while `prog_rdy` = 0.
  - The third byte is lost and `dwnld_err` = 1.
  - `dwnld_err` clears on the next rising edge of `downloading`.
- **PROM decode:** write offsets 0xE01F, 0xE020, 0xE13F, 0xE23F.
  - `prom_we` = 0001, 0010, 0100, 1000 respectively.
  - `prom_addr` = 0x1F, 0x00, 0xFF, 0xFF respectively.
- **Out-of-range byte:** write offset 0xE240 → no `prog_we` and no `prom_we`.
- **End of download with a write pending:** drop `downloading` while an SDRAM write is pending.
  - `dwnld_done` pulses one cycle after the last `prog_rdy`.
  - Asserting `rst_n` low mid-write clears `prog_we` immediately.
